btn_debounce_pulser: RTL and testbench

//  Upstream conditioning stage for the divider top: one instance per push button (BtnL->Start, BtnR->Ack).

---
 rtl/btn_debounce_pulser.sv | 60 ++++++
 tb/tb_btn_debounce_pulser.sv | 96 +++++++++
 2 files changed

// File: rtl/btn_debounce_pulser.sv
// btn_debounce_pulser: synchronize and debounce a push button, emitting a clean level plus single, repeat and continuous enables
module btn_debounce_pulser #(
  parameter int DEBOUNCE_CYCLES = 2_500_000,
  parameter int REPEAT_CYCLES   = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN,
  output logic CCEN
);
  typedef enum logic [2:0] {INI, WQ, SCEN_ST, WH, MCEN_ST, WFCR} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pb_s1_q, pb_s_q;
  always_ff @(posedge ClkPort)
    if (!Reset) begin
      state_q <= INI;
      cnt_q   <= '0;
      pb_s1_q <= 1'b0;
      pb_s_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pb_s1_q <= PB;
      pb_s_q  <= pb_s1_q;
    end
  // every transition leaves cnt_d at its cleared default; only dwelling states count
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      INI:     state_d = pb_s_q ? WQ : INI;
      WQ:
        if (!pb_s_q) state_d = INI;
        else if (cnt_q == DB_LAST) state_d = SCEN_ST;
        else cnt_d = cnt_q + CNT_W'(1);
      SCEN_ST: state_d = WH;
      WH:
        if (!pb_s_q) state_d = WFCR;
        else if (cnt_q == RP_LAST) state_d = MCEN_ST;
        else cnt_d = cnt_q + CNT_W'(1);
      MCEN_ST: state_d = WH;
      WFCR:
        if (pb_s_q) state_d = WH;
        else if (cnt_q == DB_LAST) state_d = INI;
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = INI;
    endcase
  end
  assign DPB  = state_q inside {SCEN_ST, WH, MCEN_ST, WFCR};
  assign SCEN = state_q == SCEN_ST;
  assign MCEN = state_q inside {SCEN_ST, MCEN_ST};
  assign CCEN = state_q inside {SCEN_ST, WH, MCEN_ST};
endmodule

// File: tb/tb_btn_debounce_pulser.sv
// tb_btn_debounce_pulser: directed and random button traffic against a run-length reference model, checked through a scoreboard
module tb_btn_debounce_pulser;
  localparam int D = 4;
  localparam int R = 8;
  localparam int REL = 0, SP = 1, HELD = 2, MP = 3;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic PB = 1'b0;
  logic DPB, SCEN, MCEN, CCEN;
  logic [3:0] exp_q[$];
  logic sq[$] = '{1'b0, 1'b0};
  int phase = REL, ones = 0, hold = 0, zeros = 0;
  int vectors = 0, misc = 0;
  logic [3:0] e, got;

  btn_debounce_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
    .ClkPort(clk), .Reset(Reset), .PB(PB),
    .DPB(DPB), .SCEN(SCEN), .MCEN(MCEN), .CCEN(CCEN)
  );

  always #5 clk = ~clk;

  // Reference: a press is D+1 consecutive synced highs, a release D+1 consecutive synced lows,
  // and a repeat fires after R synced highs since the last (re)entry into the held phase.
  task automatic model(input logic pb, input logic rst);
    logic s;
    if (!rst) begin
      sq = '{1'b0, 1'b0};
      phase = REL; ones = 0; hold = 0; zeros = 0;
    end else begin
      s = sq.pop_front();
      sq.push_back(pb);
      case (phase)
        REL: if (s) begin ones++; if (ones == D + 1) phase = SP; end else ones = 0;
        SP, MP: begin phase = HELD; hold = 0; zeros = 0; end
        default:
          if (zeros > 0) begin
            if (s) begin zeros = 0; hold = 0; end
            else begin zeros++; if (zeros == D + 1) begin phase = REL; ones = 0; end end
          end else if (!s) zeros = 1;
          else begin hold++; if (hold == R) phase = MP; end
      endcase
    end
    exp_q.push_back(phase == SP ? 4'b1111 : phase == MP ? 4'b1011 :
                    phase == HELD ? {1'b1, 2'b00, zeros == 0} : 4'b0000);
  endtask

  task automatic cyc(input logic pb, input logic rst);
    @(negedge clk);
    PB = pb;
    Reset = rst;
    @(posedge clk);
    model(pb, rst);
  endtask

  task automatic run(input logic pb, input int n);
    repeat (n) cyc(pb, 1'b1);
  endtask

  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      got = {DPB, SCEN, MCEN, CCEN};
      vectors++;
      if (got !== e) begin
        misc++;
        $display("FAIL outputs t=%0t DPB,SCEN,MCEN,CCEN got %b want %b", $time, got, e);
      end
    end

  initial begin
    int len;
    logic v, r;
    repeat (3) cyc(1'b1, 1'b0);
    run(1'b1, 12); run(1'b0, 12);
    run(1'b1, 30); run(1'b0, 12);
    run(1'b1, 3); run(1'b0, 1); run(1'b1, 3); run(1'b0, 10);
    run(1'b1, 15); run(1'b0, 2); run(1'b1, 20); run(1'b0, 12);
    run(1'b1, 10); run(1'b0, 12); run(1'b1, 10); run(1'b0, 12);
    run(1'b1, 7); cyc(1'b1, 1'b0); run(1'b1, 10); run(1'b0, 12);
    for (int i = 0; i < 300; i++) begin
      len = $urandom_range(1, 14);
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < len; k++) cyc(v, !(r && k == 0));
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      misc++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
